// File: rtl/tick_scheduler.sv
// tick_scheduler: clock-enable pulse generator with a fixed pixel tick and a handshake-reconfigurable slow tick
module tick_scheduler #(
  parameter int          PIX_DIV     = 4,
  parameter int          CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic             InputClock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             pix_tick,
  output logic             slow_tick,
  output logic [CNT_W-1:0] active_div
);
  localparam int PW = $clog2(PIX_DIV);
  typedef enum logic [1:0] {STOP, RUN, PEND} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d, div_next_q, div_next_d, slow_cnt_q, slow_cnt_d, cfg_div_eff;
  logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
  logic             pix_tick_q, pix_tick_d, slow_tick_q, slow_tick_d;
  logic             accept, counting, run_on, pix_wrap, slow_wrap;
  // state and datapath registers, synchronous active-low reset drops any pending divisor
  always_ff @(posedge InputClock) begin
    if (!rst_n) begin
      state_q     <= STOP;
      div_q       <= CNT_W'(DEFAULT_DIV);
      div_next_q  <= '0;
      pix_cnt_q   <= '0;
      slow_cnt_q  <= '0;
      pix_tick_q  <= 1'b0;
      slow_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      div_next_q  <= div_next_d;
      pix_cnt_q   <= pix_cnt_d;
      slow_cnt_q  <= slow_cnt_d;
      pix_tick_q  <= pix_tick_d;
      slow_tick_q <= slow_tick_d;
    end
  end
  // next state: a pending divisor leaves PEND only at a slow wrap or when stopped
  always_comb begin
    state_d = state_q == STOP ? (enable ? RUN : STOP) :
              !enable         ? STOP :
              state_q == RUN  ? (accept ? PEND : RUN) :
              slow_wrap       ? RUN : PEND;
  end
  // outputs decoded from state alone so ready never depends on cfg_valid
  always_comb begin
    cfg_ready  = state_q != PEND;
    pix_tick   = pix_tick_q;
    slow_tick  = slow_tick_q;
    active_div = div_q;
  end
  // counters, registered ticks and divisor commit on the period boundary
  always_comb begin
    accept      = cfg_valid & cfg_ready;
    cfg_div_eff = cfg_div == '0 ? CNT_W'(1) : cfg_div;
    counting    = state_q != STOP;
    run_on      = counting & enable;
    pix_wrap    = counting && pix_cnt_q == PW'(PIX_DIV - 1);
    slow_wrap   = counting && slow_cnt_q == div_q - 1'b1;
    pix_cnt_d   = run_on && !pix_wrap ? pix_cnt_q + 1'b1 : '0;
    slow_cnt_d  = run_on && !slow_wrap ? slow_cnt_q + 1'b1 : '0;
    pix_tick_d  = run_on & pix_wrap;
    slow_tick_d = run_on & slow_wrap;
    div_d       = accept && (state_q == STOP || !enable)                ? cfg_div_eff :
                  state_q == PEND && (!enable || slow_wrap)              ? div_next_q  : div_q;
    div_next_d  = accept && state_q == RUN && enable ? cfg_div_eff : div_next_q;
  end
endmodule
